particle_jitter: RTL and testbench

- Consumes the 4-bit LFSR nibble stream from the random-number top (o_random_out) and turns it into jittered candidate particle centres for the tracker.
- For each of N_PART particles: packs two nibbles into a signed X offset and two into a signed Y offset, scales each offset, adds it to a latched base centre and clamps the result to the frame.
- Sits directly downstream of the random generator and upstream of the per-particle similarity PE.

---
 rtl/particle_jitter.sv | 242 ++++++++++++++++++++++++
 tb/tb_particle_jitter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/particle_jitter.sv
// particle_jitter
//
// Turns the 4-bit random nibble stream into jittered candidate particle
// centres. For each of N_PART particles four nibbles are collected (X high,
// X low, Y high, Y low), each 8-bit raw offset is arithmetically shifted
// right by OFF_SHIFT, added to the centre latched at start, and clamped to
// the frame [0, FRAME_W-1] x [0, FRAME_H-1].
//
// Handshakes (both directions use the same rule): a transfer happens on a
// rising clock edge where valid and ready are both 1. The producer holds
// its data stable while valid is high and ready is low. Ready does not
// depend on valid.
//   - Nibble input: i_rnd_valid / o_rnd_ready (ready only while collecting).
//   - Particle output: o_valid / i_ready.
//
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_start             start pulse, only looked at in IDLE
//   i_cx, i_cy          base centre, latched on accepted start
//   i_rnd, i_rnd_valid  random nibble input
//   o_rnd_ready         nibble consumed this cycle when i_rnd_valid is high
//   o_x, o_y, o_idx     jittered particle and its index
//   o_valid, i_ready    particle output handshake
//   o_busy              high in any state other than IDLE
//   o_done              one-cycle pulse after the last particle handshake
//   o_clamp_cnt         (only with JITTER_CLAMP_STATS_EN) number of X and Y
//                       clamp events in the current run
//
// Build option: define JITTER_CLAMP_STATS_EN to add the clamp counter.
//
// The FSM state is held in r_state (type state_t) for checkers to bind to.

module particle_jitter #(
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int FRAME_W   = 640,
  parameter int FRAME_H   = 480,
  parameter int N_PART    = 16,
  parameter int OFF_SHIFT = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [X_W-1:0]            i_cx,
  input  logic [Y_W-1:0]            i_cy,
  input  logic [3:0]                i_rnd,
  input  logic                      i_rnd_valid,
  output logic                      o_rnd_ready,
  output logic [X_W-1:0]            o_x,
  output logic [Y_W-1:0]            o_y,
  output logic [$clog2(N_PART)-1:0] o_idx,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_busy,
  output logic                      o_done
`ifdef JITTER_CLAMP_STATS_EN
  ,
  output logic [$clog2(2*N_PART+1)-1:0] o_clamp_cnt
`endif
);

  localparam int IDX_W = $clog2(N_PART);
  localparam logic signed [X_W+1:0] X_MAX = (X_W+2)'(FRAME_W - 1);
  localparam logic signed [Y_W+1:0] Y_MAX = (Y_W+2)'(FRAME_H - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_XH, S_XL, S_YH, S_YL, S_CALC, S_OUT, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [X_W-1:0]   r_cx;
  logic [Y_W-1:0]   r_cy;
  logic [7:0]       r_raw_x;
  logic [7:0]       r_raw_y;
  logic [IDX_W-1:0] r_idx;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [IDX_W-1:0] r_oidx;

  logic w_take;
  logic w_last;

  logic signed [7:0]     w_off_x;
  logic signed [7:0]     w_off_y;
  logic signed [X_W+1:0] w_sum_x;
  logic signed [Y_W+1:0] w_sum_y;
  logic                  w_clx_lo;
  logic                  w_clx_hi;
  logic                  w_cly_lo;
  logic                  w_cly_hi;
  logic [X_W-1:0]        w_x;
  logic [Y_W-1:0]        w_y;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_last = (r_idx == IDX_W'(N_PART - 1));

  always_comb begin
    w_next      = r_state;
    o_rnd_ready = 1'b0;
    o_valid     = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = S_XH;
      end
      S_XH: begin
        o_rnd_ready = 1'b1;
        if (i_rnd_valid) w_next = S_XL;
      end
      S_XL: begin
        o_rnd_ready = 1'b1;
        if (i_rnd_valid) w_next = S_YH;
      end
      S_YH: begin
        o_rnd_ready = 1'b1;
        if (i_rnd_valid) w_next = S_YL;
      end
      S_YL: begin
        o_rnd_ready = 1'b1;
        if (i_rnd_valid) w_next = S_CALC;
      end
      S_CALC: begin
        w_next = S_OUT;
      end
      S_OUT: begin
        o_valid = 1'b1;
        if (i_ready) w_next = w_last ? S_DONE : S_XH;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_take = o_rnd_ready && i_rnd_valid;

  // ---------------------------------------------------------------------------
  // Offset, add and clamp. Sums are two bits wider than the coordinate so
  // that both underflow (sign bit) and overflow past the frame are visible.
  // ---------------------------------------------------------------------------
  assign w_off_x = $signed(r_raw_x) >>> OFF_SHIFT;
  assign w_off_y = $signed(r_raw_y) >>> OFF_SHIFT;

  assign w_sum_x = $signed({2'b00, r_cx}) + $signed({{(X_W-6){w_off_x[7]}}, w_off_x});
  assign w_sum_y = $signed({2'b00, r_cy}) + $signed({{(Y_W-6){w_off_y[7]}}, w_off_y});

  assign w_clx_lo = w_sum_x[X_W+1];
  assign w_clx_hi = (w_sum_x > X_MAX);
  assign w_cly_lo = w_sum_y[Y_W+1];
  assign w_cly_hi = (w_sum_y > Y_MAX);

  always_comb begin
    w_x = w_sum_x[X_W-1:0];
    w_y = w_sum_y[Y_W-1:0];
    if (w_clx_lo)      w_x = '0;
    else if (w_clx_hi) w_x = X_W'(FRAME_W - 1);
    if (w_cly_lo)      w_y = '0;
    else if (w_cly_hi) w_y = Y_W'(FRAME_H - 1);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_raw_x <= '0;
      r_raw_y <= '0;
      r_idx   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_oidx  <= '0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_cx  <= i_cx;
        r_cy  <= i_cy;
        r_idx <= '0;
      end
      if (w_take) begin
        case (r_state)
          S_XH:    r_raw_x[7:4] <= i_rnd;
          S_XL:    r_raw_x[3:0] <= i_rnd;
          S_YH:    r_raw_y[7:4] <= i_rnd;
          S_YL:    r_raw_y[3:0] <= i_rnd;
          default: ;
        endcase
      end
      if (r_state == S_CALC) begin
        r_x    <= w_x;
        r_y    <= w_y;
        r_oidx <= r_idx;
      end
      if (r_state == S_OUT && i_ready && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign o_x   = r_x;
  assign o_y   = r_y;
  assign o_idx = r_oidx;

`ifdef JITTER_CLAMP_STATS_EN
  localparam int CNT_W = $clog2(2*N_PART+1);
  logic [CNT_W-1:0] r_clamp_cnt;

  // Each particle can add 0, 1 or 2 events; the counter is only touched in
  // CALC, so it is frozen from DONE until the next accepted start.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_clamp_cnt <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_clamp_cnt <= '0;
    end else if (r_state == S_CALC) begin
      r_clamp_cnt <= r_clamp_cnt + CNT_W'(w_clx_lo | w_clx_hi)
                                 + CNT_W'(w_cly_lo | w_cly_hi);
    end
  end

  assign o_clamp_cnt = r_clamp_cnt;
`endif

endmodule

// File: tb/tb_particle_jitter.sv
// Testbench for particle_jitter: directed particle streams with hand-computed
// expected coordinates held in a scoreboard queue.

module tb_particle_jitter;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [9:0]  i_cx;
  logic [8:0]  i_cy;
  logic [3:0]  i_rnd;
  logic        i_rnd_valid;
  logic        o_rnd_ready;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
  logic [3:0]  o_idx;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;
  logic        o_done;
`ifdef JITTER_CLAMP_STATS_EN
  logic [5:0]  o_clamp_cnt;
`endif

  particle_jitter dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_cx        (i_cx),
    .i_cy        (i_cy),
    .i_rnd       (i_rnd),
    .i_rnd_valid (i_rnd_valid),
    .o_rnd_ready (o_rnd_ready),
    .o_x         (o_x),
    .o_y         (o_y),
    .o_idx       (o_idx),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_done      (o_done)
`ifdef JITTER_CLAMP_STATS_EN
    ,
    .o_clamp_cnt (o_clamp_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  logic [22:0] exp_q[$];   // {idx, x, y}
  logic [3:0]  nib_q[$];   // nibbles to feed, in order

  int done_cyc;
  int first_valid;

  // Expected coordinates for the repeating nibble pattern k%16 with
  // centre (100, 50): X raw 01,45,89,CD -> off 0,17,-30,-13;
  // Y raw 23,67,AB,EF -> off 8,25,-22,-5.
  int xt[4] = '{100, 117, 70, 87};
  int yt[4] = '{58, 75, 28, 45};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic push_part(input logic [3:0] n0, input logic [3:0] n1,
                           input logic [3:0] n2, input logic [3:0] n3,
                           input int ex, input int ey);
    nib_q.push_back(n0);
    nib_q.push_back(n1);
    nib_q.push_back(n2);
    nib_q.push_back(n3);
    exp_q.push_back({4'(exp_q.size()), 10'(ex), 9'(ey)});
  endtask

  task automatic fill_pattern();
    exp_q.delete();
    nib_q.delete();
    for (int p = 0; p < 16; p++) begin
      push_part(4'((4*p) % 16), 4'((4*p+1) % 16), 4'((4*p+2) % 16), 4'((4*p+3) % 16),
                xt[p % 4], yt[p % 4]);
    end
  endtask

  // One start-to-done run. gap=1 offers a nibble only every 3rd cycle.
  // hold_idx >= 0 stalls i_ready for 20 cycles on that particle.
  // restart_at >= 0 pulses i_start (with a different centre) mid-run.
  // abort_nib >= 0 asserts reset once that many nibbles have been consumed.
  task automatic run(input logic [9:0] cx, input logic [8:0] cy, input bit gap,
                     input int hold_idx, input int restart_at, input int abort_nib);
    int cyc;
    int hs;
    int nib_used;
    bit consumed;
    bit held;
    bit fin;
    logic [22:0] e;
    cyc = 0; hs = 0; nib_used = 0; held = 0; fin = 0;
    done_cyc = -1; first_valid = -1;
    i_cx = cx; i_cy = cy; i_ready = 1'b1;
    i_rnd = nib_q[0]; i_rnd_valid = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (!fin && cyc < 800) begin
      if (abort_nib >= 0 && nib_used == abort_nib && o_rnd_ready) begin
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        check("abort_x",         32'(o_x), 32'd0);
        check("abort_y",         32'(o_y), 32'd0);
        check("abort_idx",       32'(o_idx), 32'd0);
        check("abort_valid",     32'(o_valid), 32'd0);
        check("abort_rnd_ready", 32'(o_rnd_ready), 32'd0);
        check("abort_busy",      32'(o_busy), 32'd0);
        check("abort_done",      32'(o_done), 32'd0);
        repeat (5) begin
          tick();
          check("abort_no_done", 32'(o_done), 32'd0);
        end
        exp_q.delete();
        nib_q.delete();
        i_rnd_valid = 1'b0;
        return;
      end
      if (o_valid && hold_idx >= 0 && !held && o_idx == 4'(hold_idx)) begin
        i_ready = 1'b0;
        held = 1'b1;
        repeat (20) begin
          tick();
          check("hold_valid",     32'(o_valid), 32'd1);
          check("hold_pkt",       32'({o_idx, o_x, o_y}), 32'(exp_q[0]));
          check("hold_rnd_ready", 32'(o_rnd_ready), 32'd0);
        end
        i_ready = 1'b1;
      end
      if (o_valid && i_ready) begin
        if (first_valid < 0) first_valid = cyc;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("pkt", 32'({o_idx, o_x, o_y}), 32'(e));
        hs++;
      end
      if (o_done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end
      consumed = o_rnd_ready && i_rnd_valid;
      if (restart_at >= 0 && cyc == restart_at) begin
        i_start = 1'b1;
        i_cx = 10'd600;
        i_cy = 9'd10;
      end else begin
        i_start = 1'b0;
      end
      tick();
      cyc++;
      if (consumed) begin
        nib_used++;
        if (nib_q.size() > 0) void'(nib_q.pop_front());
      end
      i_rnd = (nib_q.size() > 0) ? nib_q[0] : 4'h0;
      i_rnd_valid = gap ? (cyc % 3 == 0) : 1'b1;
    end
    i_start = 1'b0;
    check("done_seen",       32'(fin), 32'd1);
    check("busy_after_done", 32'(o_busy), 32'd0);
    check("done_once",       32'(o_done), 32'd0);
    check("valid_after_done", 32'(o_valid), 32'd0);
    check("handshakes",      32'(hs), 32'd16);
    check("exp_empty",       32'(exp_q.size()), 32'd0);
    i_rnd_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_cx = '0; i_cy = '0;
    i_rnd = '0; i_rnd_valid = 1'b0; i_ready = 1'b0;
    repeat (3) tick();
    check("rst_x",         32'(o_x), 32'd0);
    check("rst_y",         32'(o_y), 32'd0);
    check("rst_idx",       32'(o_idx), 32'd0);
    check("rst_valid",     32'(o_valid), 32'd0);
    check("rst_rnd_ready", 32'(o_rnd_ready), 32'd0);
    check("rst_busy",      32'(o_busy), 32'd0);
    check("rst_done",      32'(o_done), 32'd0);
    i_rst_n = 1'b1;
    repeat (10) tick();

    // Basic offsets (X +2, Y -1) and a 20-cycle stall on particle 0.
    exp_q.delete(); nib_q.delete();
    push_part(4'h0, 4'h8, 4'hF, 4'hC, 322, 239);
    for (int p = 1; p < 16; p++) push_part(4'h0, 4'h0, 4'h0, 4'h0, 320, 240);
    run(10'd320, 9'd240, 1'b0, 0, -1, -1);
    check("latency_a", 32'(first_valid), 32'd5);
    check("last_x_held", 32'(o_x), 32'd320);
    check("last_y_held", 32'(o_y), 32'd240);

    // Clamping at both ends: X 5-32 -> 0, Y 470+31 -> 479.
    exp_q.delete(); nib_q.delete();
    push_part(4'h8, 4'h0, 4'h7, 4'hF, 0, 479);
    for (int p = 1; p < 16; p++) push_part(4'h0, 4'h0, 4'h0, 4'h0, 5, 470);
    run(10'd5, 9'd470, 1'b0, -1, -1, -1);
`ifdef JITTER_CLAMP_STATS_EN
    check("clamp_cnt_2", 32'(o_clamp_cnt), 32'd2);
    repeat (3) tick();
    check("clamp_cnt_stable", 32'(o_clamp_cnt), 32'd2);
`endif

    // Continuous back-to-back run: 1 particle per 6 cycles.
    fill_pattern();
    run(10'd100, 9'd50, 1'b0, -1, -1, -1);
    check("latency_c", 32'(first_valid), 32'd5);
    check("run_cycles", 32'(done_cyc >= 94 && done_cyc <= 98), 32'd1);
`ifdef JITTER_CLAMP_STATS_EN
    check("clamp_cnt_0", 32'(o_clamp_cnt), 32'd0);
`endif

    // Gapped nibbles plus an ignored second start with another centre.
    fill_pattern();
    run(10'd100, 9'd50, 1'b1, -1, 20, -1);

    // Reset during YL of particle 7 (31 nibbles consumed), then a fresh run.
    fill_pattern();
    run(10'd100, 9'd50, 1'b0, -1, -1, 31);
    fill_pattern();
    run(10'd100, 9'd50, 1'b0, -1, -1, -1);
    check("run_cycles_f", 32'(done_cyc >= 94 && done_cyc <= 98), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
